// File: rtl/led_count_7seg_scan.sv
// led_count_7seg_scan
// Converts an 8-bit binary count to three BCD digits with a sequential
// double-dabble engine (one shift step per clock), holds the result in a
// display register and scans it onto a 3-digit common-anode 7-segment
// display with optional leading-zero blanking.
module led_count_7seg_scan #(
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  // Prescaler width; a divide of 1 still needs a 1-bit counter.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Converter state
  // ---------------------------------------------------------------------
  state_t      state, state_next;
  logic [19:0] shift, shift_next;   // {hundreds, tens, units, binary}
  logic [19:0] shift_adj;           // shift with the +3 correction applied
  logic [19:0] shift_step;          // one complete double-dabble step
  logic [2:0]  step, step_next;
  logic        pending, pending_next;
  logic [7:0]  pend_val, pend_val_next;
  logic        busy_next;
  logic        done_next;
  logic [11:0] bcd_next;

  // All three BCD nibbles are corrected in parallel before the shift, so
  // each nibble sees its own pre-step value rather than a neighbour's
  // already-corrected one.
  assign shift_adj[7:0] = shift[7:0];
  for (genvar gi = 0; gi < 3; gi++) begin : g_adjust
    logic [3:0] nib;
    assign nib = shift[8 + 4*gi +: 4];
    assign shift_adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  end

  // The MSB shifted out is always zero for inputs up to 255.
  assign shift_step = shift_adj << 1;

  // Converter state register and display register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= 20'd0;
      step     <= 3'd0;
      pending  <= 1'b0;
      pend_val <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= 12'd0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      step     <= step_next;
      pending  <= pending_next;
      pend_val <= pend_val_next;
      busy     <= busy_next;
      done     <= done_next;
      bcd      <= bcd_next;
    end
  end

  // Next-state logic for the conversion FSM, including the pending slot
  // that remembers only the most recent load seen while busy.
  always_comb begin
    state_next    = state;
    shift_next    = shift;
    step_next     = step;
    pending_next  = pending;
    pend_val_next = pend_val;
    busy_next     = busy;
    done_next     = 1'b0;
    bcd_next      = bcd;

    case (state)
      IDLE: begin
        if (load) begin
          shift_next = {12'd0, value};
          step_next  = 3'd0;
          state_next = SHIFT;
          busy_next  = 1'b1;
        end
      end

      SHIFT: begin
        shift_next = shift_step;
        if (step == 3'd7) begin
          state_next = DONE;
        end else begin
          step_next = step + 3'd1;
        end
        if (load) begin
          pending_next  = 1'b1;
          pend_val_next = value;
        end
      end

      DONE: begin
        bcd_next  = shift[19:8];
        done_next = 1'b1;
        // A load arriving in this very cycle is newer than anything held
        // in the pending slot, so it takes precedence.
        if (load || pending) begin
          shift_next   = {12'd0, (load ? value : pend_val)};
          step_next    = 3'd0;
          state_next   = SHIFT;
          pending_next = 1'b0;
          busy_next    = 1'b1;
        end else begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    digit;
  logic [2:0]    digit_blank;
  logic [6:0]    digit_seg [3];
  logic [6:0]    cur_seg;
  logic [2:0]    cur_an;

  assign tick = (presc == PRESC_LAST);

  // Units are never blanked; tens only when hundreds is also zero.
  assign digit_blank[0] = 1'b0;
  assign digit_blank[1] = BLANK_LEADING && (bcd[11:4] == 8'd0);
  assign digit_blank[2] = BLANK_LEADING && (bcd[11:8] == 4'd0);

  // Segment pattern for each digit, derived only from the display register
  // so a half-converted value is never visible.
  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    assign digit_seg[gi] = digit_blank[gi] ? 7'h7F : seg7(bcd[4*gi +: 4]);
  end

  // Pattern and anode select for the digit about to be shown.
  always_comb begin
    cur_seg = 7'h7F;
    cur_an  = 3'b111;
    case (digit)
      2'd0: begin
        cur_seg = digit_seg[0];
        cur_an  = 3'b110;
      end
      2'd1: begin
        cur_seg = digit_seg[1];
        cur_an  = 3'b101;
      end
      2'd2: begin
        cur_seg = digit_seg[2];
        cur_an  = 3'b011;
      end
      default: begin
        cur_seg = 7'h7F;
        cur_an  = 3'b111;
      end
    endcase
  end

  // Prescaler and digit rotation; outputs are registered on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      digit <= 2'd0;
      an    <= 3'b111;
      seg   <= 7'h7F;
    end else if (tick) begin
      presc <= '0;
      an    <= cur_an;
      seg   <= cur_seg;
      digit <= (digit == 2'd2) ? 2'd0 : (digit + 2'd1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule
